// File: rtl/mipi_iodelay_array_if.sv
// rtl/mipi_iodelay_array_if.sv - command port bundle for the lane delay array
// Purpose: groups the tap command handshake (valid/ready plus payload).
// Signals:
//   cmd_valid  command request from the controller
//   cmd_ready  command accepted when cmd_valid & cmd_ready
//   cmd_op     00 LOAD, 01 INC, 10 DEC, 11 RESET
//   cmd_lane   target lane
//   cmd_value  tap for LOAD
// Modports: master drives the command, slave (the delay array) returns ready.
interface mipi_iodelay_array_if #(
  parameter int LANE_NBIT  = 2,
  parameter int DELAY_NBIT = 5
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [LANE_NBIT-1:0]  cmd_lane;
  logic [DELAY_NBIT-1:0] cmd_value;

  modport master (output cmd_valid, output cmd_op, output cmd_lane, output cmd_value,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, input  cmd_lane, input  cmd_value,
                  output cmd_ready);
endinterface

// File: rtl/mipi_iodelay_array.sv
// rtl/mipi_iodelay_array.sv - multi-lane run-time adjustable MIPI input delay line
// Purpose: per-lane tapped shift line between lane input registers and the
//   deserialiser. Taps change through one command port; after a tap change the
//   lane output is frozen at its last value for SETTLE_CYC cycles.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   in_dio       lane inputs, bit i = lane i
//   cmd          command port (slave modport of mipi_iodelay_array_if)
//   out_dio      delayed lane outputs
//   busy         lane i is settling
//   err          1-cycle pulse on rejected or saturated command
//   rd_tap       per-lane tap readback, only with MIPI_IODELAY_READBACK_EN defined
module mipi_iodelay_array #(
  parameter int NUM_LANES  = 4,
  parameter int LANE_NBIT  = 2,
  parameter int DELAY_NBIT = 5,
  parameter int DELAY_INIT = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_LANES-1:0]     in_dio,
  mipi_iodelay_array_if.slave      cmd,
  output logic [NUM_LANES-1:0]     out_dio,
  output logic [NUM_LANES-1:0]     busy,
  output logic                     err
`ifdef MIPI_IODELAY_READBACK_EN
  ,
  output logic [NUM_LANES*DELAY_NBIT-1:0] rd_tap
`else
`endif
);

  localparam int TAPS = 2**DELAY_NBIT;
  localparam logic [DELAY_NBIT-1:0] TAP_MAX  = {DELAY_NBIT{1'b1}};
  localparam logic [DELAY_NBIT-1:0] TAP_INIT = DELAY_NBIT'(DELAY_INIT);
  localparam logic [3:0]            CNT_LOAD = 4'(SETTLE_CYC - 1);

  typedef enum logic {ST_IDLE, ST_SETTLE} state_t;

  state_t                state_q [NUM_LANES];
  state_t                state_d [NUM_LANES];
  logic [3:0]            cnt_q   [NUM_LANES];
  logic [3:0]            cnt_d   [NUM_LANES];
  logic [DELAY_NBIT-1:0] tap_q   [NUM_LANES];
  logic [DELAY_NBIT-1:0] tap_d   [NUM_LANES];
  logic [TAPS-1:0]       line_q  [NUM_LANES];
  logic [NUM_LANES-1:0]  hold_q;
  logic [NUM_LANES-1:0]  clear_d;
  logic                  err_d;
  logic                  ready_c;
  logic                  lane_ok;
  logic                  cmd_acc;

  // Out-of-range lanes never block: they are accepted and flagged as errors.
  always_comb begin
    ready_c = 1'b1;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (cmd.cmd_lane == LANE_NBIT'(i) && state_q[i] == ST_SETTLE) ready_c = 1'b0;
    end
  end

  assign cmd.cmd_ready = ready_c;
  assign lane_ok       = (int'(cmd.cmd_lane) < NUM_LANES);
  assign cmd_acc       = cmd.cmd_valid & ready_c;

  always_comb begin
    logic chg;
    err_d = cmd_acc & ~lane_ok;
    for (int i = 0; i < NUM_LANES; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      tap_d[i]   = tap_q[i];
      clear_d[i] = 1'b0;
      chg        = 1'b0;
      if (state_q[i] == ST_SETTLE) begin
        if (cnt_q[i] == 4'd0) state_d[i] = ST_IDLE;
        else                  cnt_d[i]   = cnt_q[i] - 4'd1;
      end
      // A hit lane is always idle, since ready is low while it settles.
      if (cmd_acc && lane_ok && cmd.cmd_lane == LANE_NBIT'(i)) begin
        case (cmd.cmd_op)
          2'b00: begin
            if (cmd.cmd_value != tap_q[i]) begin
              tap_d[i] = cmd.cmd_value;
              chg      = 1'b1;
            end
          end
          2'b01: begin
            if (tap_q[i] == TAP_MAX) err_d = 1'b1;
            else begin
              tap_d[i] = tap_q[i] + 1'b1;
              chg      = 1'b1;
            end
          end
          2'b10: begin
            if (tap_q[i] == '0) err_d = 1'b1;
            else begin
              tap_d[i] = tap_q[i] - 1'b1;
              chg      = 1'b1;
            end
          end
          default: begin
            tap_d[i]   = TAP_INIT;
            clear_d[i] = 1'b1;
            chg        = 1'b1;
          end
        endcase
      end
      if (chg) begin
        state_d[i] = ST_SETTLE;
        cnt_d[i]   = CNT_LOAD;
      end
    end
  end

  // While settling the output comes from hold, so capturing out_dio every
  // cycle keeps hold frozen at the last pre-change value.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      busy[i]    = (state_q[i] == ST_SETTLE);
      out_dio[i] = busy[i] ? hold_q[i] : line_q[i][tap_q[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= 4'd0;
        tap_q[i]   <= TAP_INIT;
        line_q[i]  <= '0;
      end
      hold_q <= '0;
      err    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        tap_q[i]   <= tap_d[i];
        line_q[i]  <= clear_d[i] ? '0 : {line_q[i][TAPS-2:0], in_dio[i]};
      end
      hold_q <= out_dio;
      err    <= err_d;
    end
  end

`ifdef MIPI_IODELAY_READBACK_EN
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_rd
    assign rd_tap[g*DELAY_NBIT +: DELAY_NBIT] = tap_q[g];
  end
`else
`endif

endmodule

// File: tb/tb_mipi_iodelay_array.sv
// tb/tb_mipi_iodelay_array.sv - scoreboard bench for mipi_iodelay_array
// Purpose: drives directed and random commands/lane data, predicts every
//   cycle's outputs from an input-history model, and checks them in a monitor.
module tb_mipi_iodelay_array;
  localparam int NL = 4, LB = 3, DB = 5, INIT = 16, SC = 4, TMAX = 31, MAXC = 6000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NL-1:0] in_dio = '0;
  logic [NL-1:0] out_dio;
  logic [NL-1:0] busy;
  logic          err;
`ifdef MIPI_IODELAY_READBACK_EN
  logic [NL*DB-1:0] rd_tap;
`else
`endif

  mipi_iodelay_array_if #(.LANE_NBIT(LB), .DELAY_NBIT(DB)) cmd_if ();

  mipi_iodelay_array #(
    .NUM_LANES(NL), .LANE_NBIT(LB), .DELAY_NBIT(DB), .DELAY_INIT(INIT), .SETTLE_CYC(SC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_dio(in_dio), .cmd(cmd_if.slave),
    .out_dio(out_dio), .busy(busy), .err(err)
`ifdef MIPI_IODELAY_READBACK_EN
    , .rd_tap(rd_tap)
`else
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           chk;
    int           cyc;
    bit [NL-1:0]  out;
    bit [NL-1:0]  bsy;
    bit           ready;
    bit           err;
    bit [NL*DB-1:0] taps;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0, n_fail = 0;

  // Reference model: taps, settle end cycle, frozen value, and the cycle up
  // to which a lane's history has been wiped by reset/RESET.
  int          cyc = 0;
  bit          model_valid = 0;
  int          tap_m    [NL];
  int          busy_end [NL];
  int          clear_c  [NL];
  bit          frozen   [NL];
  bit          err_pend = 0;
  bit [NL-1:0] hist [MAXC];

  function automatic bit sample(input int i, input int k);
    if (k < 0 || k <= clear_c[i]) return 1'b0;
    return hist[k][i];
  endfunction

  task automatic check(input string nm, input int c, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d got 0x%0h want 0x%0h", nm, c, got, want);
    end
  endtask

  task automatic step(input bit rst, input bit [NL-1:0] din, input bit v,
                      input bit [1:0] op, input int lane, input int val);
    exp_t        e;
    bit [NL-1:0] cur;
    int          nt;
    bit          ch;
    @(posedge clk);
    #1;
    rst_n            = !rst;
    in_dio           = din;
    cmd_if.cmd_valid = v;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_lane  = LB'(lane);
    cmd_if.cmd_value = DB'(val);
    for (int i = 0; i < NL; i++) begin
      e.bsy[i] = (cyc <= busy_end[i]);
      cur[i]   = e.bsy[i] ? frozen[i] : sample(i, cyc - 1 - tap_m[i]);
      e.taps[i*DB +: DB] = DB'(tap_m[i]);
    end
    e.out   = cur;
    e.ready = (lane >= NL) ? 1'b1 : !e.bsy[lane];
    e.err   = err_pend;
    e.chk   = model_valid;
    e.cyc   = cyc;
    sb.push_back(e);
    hist[cyc] = din;
    err_pend  = 0;
    if (rst) begin
      for (int i = 0; i < NL; i++) begin
        tap_m[i] = INIT; busy_end[i] = -1; clear_c[i] = cyc; frozen[i] = 0;
      end
      model_valid = 1;
    end else if (v && e.ready) begin
      if (lane >= NL) err_pend = 1;
      else begin
        nt = tap_m[lane];
        ch = 0;
        case (op)
          2'd0: if (val != nt) begin nt = val; ch = 1; end
          2'd1: if (nt == TMAX) err_pend = 1; else begin nt = nt + 1; ch = 1; end
          2'd2: if (nt == 0) err_pend = 1; else begin nt = nt - 1; ch = 1; end
          default: begin nt = INIT; ch = 1; clear_c[lane] = cyc; end
        endcase
        if (ch) begin
          tap_m[lane]    = nt;
          busy_end[lane] = cyc + SC;
          frozen[lane]   = cur[lane];
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit rnd);
    for (int k = 0; k < n; k++) step(0, rnd ? NL'($urandom) : '0, 0, 0, 0, 0);
  endtask

  task automatic cmd(input bit [1:0] op, input int lane, input int val);
    step(0, NL'($urandom), 1, op, lane, val);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          check("out_dio",   e.cyc, 32'(out_dio),        32'(e.out));
          check("busy",      e.cyc, 32'(busy),           32'(e.bsy));
          check("cmd_ready", e.cyc, 32'(cmd_if.cmd_ready), 32'(e.ready));
          check("err",       e.cyc, 32'(err),            32'(e.err));
`ifdef MIPI_IODELAY_READBACK_EN
          check("rd_tap",    e.cyc, 32'(rd_tap),         32'(e.taps));
`else
`endif
        end
      end
    end
  end

  initial begin : driver
    int op, lane, val;
    for (int k = 0; k < 3; k++) step(1, '0, 0, 0, 0, 0);
    idle(2, 0);
    step(0, 4'b0001, 0, 0, 0, 0);          // lane0 pulse, tap 16
    idle(20, 0);
    step(0, '0, 1, 2'd0, 1, 3);            // LOAD lane1 = 3
    idle(5, 0);
    step(0, 4'b0010, 0, 0, 0, 0);
    idle(6, 0);
    step(0, '0, 1, 2'd0, 2, 31);           // saturate lane2 high
    idle(6, 1);
    step(0, '0, 1, 2'd1, 2, 0);            // INC at max
    idle(3, 1);
    step(0, '0, 1, 2'd0, 2, 0);
    idle(6, 1);
    step(0, '0, 1, 2'd2, 2, 0);            // DEC at zero
    idle(3, 1);
    step(0, '0, 1, 2'd0, 5, 7);            // out-of-range lane
    step(0, '0, 1, 2'd1, 5, 0);
    idle(3, 1);
    step(0, '0, 1, 2'd0, 0, 16);           // LOAD same tap: no-op
    idle(2, 1);
    cmd(2'd0, 0, 5);                       // back-to-back lane0, lane3 in window
    cmd(2'd0, 0, 9);
    cmd(2'd0, 3, 2);
    for (int k = 0; k < 4; k++) cmd(2'd0, 0, 9);
    idle(6, 1);
    cmd(2'd3, 1, 0);                       // RESET op lane1
    idle(30, 1);
    cmd(2'd0, 0, 20);
    idle(2, 1);
    step(1, '0, 0, 0, 0, 0);               // reset during lane0 settle
    idle(25, 1);
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 499) == 0) step(1, NL'($urandom), 0, 0, 0, 0);
      else if ($urandom_range(0, 2) == 0) begin
        op   = $urandom_range(0, 3);
        lane = $urandom_range(0, 5);
        case ($urandom_range(0, 3))
          0: val = 0;
          1: val = TMAX;
          default: val = $urandom_range(0, TMAX);
        endcase
        step(0, NL'($urandom), 1, 2'(op), lane, val);
      end else idle(1, 1);
    end
    idle(2, 0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", cyc, 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
